motor_relu_seq: RTL and testbench
=================================

Name: motor_relu_seq

Overview:
Block-level sequencer for the 16-bit fixed-point (ap_fixed<16,7>) ReLU stage of the motor MPC network. It accepts one hidden-layer vector as N_BEATS beats of LANES words each, and passes every beat through a shared LANES-wide ReLU core. The result is held in a single registered pipeline stage with valid/ready backpressure. Run control uses the HLS block protocol (ap_start/ap_done/ap_idle/ap_ready) so the top-level network scheduler can chain it between dense layers.

Parameters:
W, 16, word width (fixed-point, 7 integer bits incl. sign)
LANES, 4, words per beat (ReLU core width)
N_BEATS, 4, beats per layer vector (layer size = LANES*N_BEATS)

Ports:
ap_clk  in  1  clock, rising edge
ap_rst_n  in  1  asynchronous active-low reset
ap_start  in  1  run request, sampled in IDLE
ap_done  out  1  one-cycle pulse: last output beat consumed
ap_idle  out  1  high in IDLE
ap_ready  out  1  one-cycle pulse: last input beat accepted
cfg_bypass  in  1  1 = pass-through (linear activation); latched at start
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid&in_ready
in_data  in  LANES*W  lane i at [i*W +: W], signed
out_valid  out  1  output register holds a beat
out_ready  in  1  downstream accepts when out_valid&out_ready
out_data  out  LANES*W  activated beat, same lane packing
out_last  out  1  high with the final beat of the vector

Behaviour:
- Reset (ap_rst_n=0, async): state=IDLE; in_cnt=out_cnt=0; out_valid=0; out_data=0; out_last=0; ap_done=0; ap_ready=0; ap_idle=1; bypass_q=0. Reset applied mid-vector discards the vector; the vector is not resumed.
- Per-lane function: relu(x) = ($signed(x) > 0) ? {1'b0, x[W-2:0]} : 0. Examples: 0x0000->0, 0x8000->0, 0x7FFF->0x7FFF. Bypass: output = x unchanged.
- States:
  IDLE: ap_idle=1, in_ready=0. If ap_start=1, latch cfg_bypass and clear counters -> RUN.
  RUN: in_ready = (in_cnt < N_BEATS) & (!out_valid | out_ready). On accept, register f(in_data) into out_data, set out_valid, set out_last=(in_cnt==N_BEATS-1), then in_cnt++. Accepting the beat with in_cnt==N_BEATS-1 pulses ap_ready in the next cycle and goes -> DRAIN.
  DRAIN: in_ready=0. When out_valid&out_ready&out_last -> DONE.
  DONE: ap_done=1 for one cycle -> IDLE unconditionally.
- Output handshake: on out_valid&out_ready, out_cnt++ and out_valid drops unless a new beat is accepted in the same cycle. Simultaneous consume+accept keeps full throughput of 1 beat/cycle. out_data and out_last stay stable while out_valid&!out_ready.
- Latency: input accept -> out_valid is 1 cycle. Minimum run length is N_BEATS+2 cycles from start to ap_done. An ap_start held high restarts after one IDLE cycle.
- in_valid while IDLE or DRAIN: ignored (in_ready=0); no beat is consumed.
- Counter width is $clog2(N_BEATS+1). Counters never wrap: they clear only on start and on reset.
- cfg_bypass changes during a run have no effect.
- Verification assertion: out_cnt == N_BEATS on entry to DONE.

Decomposition:
- Package motor_relu_pkg: W, LANES, the state encoding (IDLE, RUN, DRAIN, DONE, 2-bit), and the relu function.
- Sub-module motor_relu_core: combinational LANES-wide ReLU with a bypass input, instantiated once. The sequencer owns all state.

Test Plan:
- Basic run, bypass=0, 4 beats, beat0 = {0x0100, 0xFF00, 0x0000, 0x7FFF} -> out beat0 {0x0100, 0x0000, 0x0000, 0x7FFF}; out_last only on beat3; ap_ready one cycle after the beat3 accept; single ap_done pulse; ap_idle returns to 1.
- Boundary lanes {0x8000, 0x0001, 0xFFFF, 0x4000} -> {0x0000, 0x0001, 0x0000, 0x4000}.
- Backpressure: out_ready=0 for 5 cycles after beat1 -> in_ready=0, out_data holds beat1 stable, no beat lost or duplicated; with out_ready=1 the run sustains 1 beat/cycle.
- Bypass: cfg_bypass=1 at start, then toggled mid-run -> all four beats equal the inputs bit-exact (e.g. 0xFF00 stays 0xFF00).
- Reset: assert ap_rst_n=0 after beat2 -> out_valid/ap_done/ap_ready drop immediately, state IDLE; next start processes a fresh 4-beat vector correctly.
- ap_start held high, in_valid always high -> back-to-back runs, one IDLE cycle between ap_done and the next first accept; in_valid during DRAIN is not consumed.

Source files
------------

// File: rtl/motor_relu_pkg.sv
// Shared definitions for the motor MPC ReLU stage: word/beat geometry,
// the sequencer state encoding and the per-lane activation function.
package motor_relu_pkg;

    // Fixed-point word: ap_fixed<16,7>, 7 integer bits including sign.
    localparam int W = 16;
    // Words per beat; this is also the width of the shared ReLU core.
    localparam int LANES = 4;
    // Default number of beats per hidden-layer vector.
    localparam int N_BEATS_DEF = 4;
    // Packed beat width.
    localparam int DW = LANES * W;

    // Sequencer states. Kept as plain 2-bit constants so existing
    // scheduler debug tooling can decode them without the package enum.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef logic [W-1:0]  word_t;
    typedef logic [DW-1:0] beat_t;

    // ReLU on one signed fixed-point word. A strictly positive value has a
    // clear sign bit and a non-zero magnitude, and passes through with the
    // sign bit forced low; zero and all negative values map to zero.
    function automatic word_t relu(input word_t x);
        word_t r;
        if (!x[W-1] && (x[W-2:0] != '0)) begin
            r = {1'b0, x[W-2:0]};
        end else begin
            r = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/motor_relu_seq_if.sv
// Beat streaming interface between the network scheduler and the ReLU
// sequencer: one input stream and one output stream, LANES words per beat.
//
// Handshake: on both streams a beat transfers on a rising clock edge where
// valid and ready are both high. A source holds valid and its data stable
// until the transfer; a sink may raise or drop ready at any time, and
// ready may depend combinationally on valid-side state.
interface motor_relu_seq_if;
    import motor_relu_pkg::*;

    logic  in_valid;
    logic  in_ready;
    beat_t in_data;    // lane i at [i*W +: W], signed
    logic  out_valid;
    logic  out_ready;
    beat_t out_data;   // same lane packing as in_data
    logic  out_last;   // marks the final beat of a vector

    // Producer of input beats / consumer of output beats.
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_last
    );

    // The sequencer side.
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_last
    );

endinterface

// File: rtl/motor_relu_core.sv
// Combinational LANES-wide activation core. With bypass set the beat passes
// through untouched (linear activation); otherwise every lane goes through
// ReLU independently. Holds no state; the sequencer owns all registers.
module motor_relu_core
    import motor_relu_pkg::*;
(
    input  logic  bypass,
    input  beat_t din,
    output beat_t dout
);

    // Per-lane activation, default pass-through so bypass needs no extra mux.
    always_comb begin
        dout = din;
        for (int i = 0; i < LANES; i++) begin
            if (!bypass) begin
                dout[i*W +: W] = relu(din[i*W +: W]);
            end
        end
    end

endmodule

// File: rtl/motor_relu_seq.sv
// Block sequencer for the ReLU stage of the motor MPC network. Takes one
// hidden-layer vector as N_BEATS input beats, activates each beat through
// the shared core and holds the result in a single output register with
// valid/ready backpressure. Run control follows the HLS block protocol
// (ap_start/ap_done/ap_idle/ap_ready) so the scheduler can chain it
// between dense layers.
module motor_relu_seq
    import motor_relu_pkg::*;
#(
    parameter int N_BEATS = N_BEATS_DEF
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             ap_start,
    output logic             ap_done,
    output logic             ap_idle,
    output logic             ap_ready,
    input  logic             cfg_bypass,
    motor_relu_seq_if.slave  s,
    output logic [1:0]       dbg_state
);

    // Counters span 0..N_BEATS inclusive and never wrap within a run.
    localparam int CW = $clog2(N_BEATS + 1);
    localparam logic [CW-1:0] BEATS    = CW'(N_BEATS);
    localparam logic [CW-1:0] LAST_IDX = CW'(N_BEATS - 1);

    logic [1:0]    state;
    logic [CW-1:0] in_cnt;
    logic [CW-1:0] out_cnt;
    logic          bypass_q;

    logic          out_valid_q;
    beat_t         out_data_q;
    logic          out_last_q;
    logic          ap_ready_q;

    beat_t         core_out;
    logic          in_ready_c;
    logic          accept;
    logic          consume;
    logic          accept_last;

    // Shared activation core, fed straight from the input bus so an accepted
    // beat lands in the output register one cycle later.
    motor_relu_core u_core (
        .bypass (bypass_q),
        .din    (s.in_data),
        .dout   (core_out)
    );

    // Input is taken only while running, while beats remain, and while the
    // output register is empty or being emptied this same cycle; the last
    // term is what sustains one beat per cycle under continuous out_ready.
    always_comb begin
        in_ready_c  = (state == S_RUN) && (in_cnt < BEATS) &&
                      (!out_valid_q || s.out_ready);
        accept      = s.in_valid && in_ready_c;
        consume     = out_valid_q && s.out_ready;
        accept_last = accept && (in_cnt == LAST_IDX);
    end

    // Run-control FSM plus beat counters; start clears the counters, the
    // consumed-beat count runs in every state that can hold an output.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state    <= S_IDLE;
            in_cnt   <= '0;
            out_cnt  <= '0;
            bypass_q <= 1'b0;
        end else begin
            if (consume) begin
                out_cnt <= out_cnt + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        bypass_q <= cfg_bypass;
                        in_cnt   <= '0;
                        out_cnt  <= '0;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        in_cnt <= in_cnt + 1'b1;
                        if (accept_last) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (consume && out_last_q) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Output register: load on accept, empty on consume without a refill,
    // otherwise hold so data and last stay stable under backpressure.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= core_out;
            out_last_q  <= (in_cnt == LAST_IDX);
        end else if (consume) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end
    end

    // ap_ready pulses the cycle after the final input beat is accepted, so
    // the upstream layer may begin producing the next vector.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ap_ready_q <= 1'b0;
        end else begin
            ap_ready_q <= accept_last;
        end
    end

    assign ap_done     = (state == S_DONE);
    assign ap_idle     = (state == S_IDLE);
    assign ap_ready    = ap_ready_q;
    assign dbg_state   = state;

    assign s.in_ready  = in_ready_c;
    assign s.out_valid = out_valid_q;
    assign s.out_data  = out_data_q;
    assign s.out_last  = out_last_q;

    // Every beat of the vector has left the block by the time DONE is reached.
    a_done_count: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
        (state == S_DONE) |-> (out_cnt == BEATS));

    // A stalled output beat must not change until it is taken.
    a_out_stable: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
        (out_valid_q && !s.out_ready) |=> (out_valid_q && $stable(out_data_q) &&
                                           $stable(out_last_q)));

    // No input is taken outside RUN.
    a_no_accept_outside_run: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
        (state != S_RUN) |-> !in_ready_c);

endmodule

// File: tb/tb_motor_relu_seq.sv
// Bench for motor_relu_seq: directed vectors, a cycle-by-cycle reference
// model of the block protocol and data path, and literal expectations.
module tb_motor_relu_seq;
    import motor_relu_pkg::*;

    localparam int NB = 4;

    // ---------------- clock / reset ----------------
    logic       ap_clk = 1'b0;
    logic       ap_rst_n = 1'b0;
    logic       ap_start = 1'b0;
    logic       cfg_bypass = 1'b0;
    logic       ap_done;
    logic       ap_idle;
    logic       ap_ready;
    logic [1:0] dbg_state;
    int         cyc = 0;

    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc <= cyc + 1;

    motor_relu_seq_if bus ();

    motor_relu_seq #(.N_BEATS(NB)) dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .ap_start   (ap_start),
        .ap_done    (ap_done),
        .ap_idle    (ap_idle),
        .ap_ready   (ap_ready),
        .cfg_bypass (cfg_bypass),
        .s          (bus),
        .dbg_state  (dbg_state)
    );

    // ---------------- check bookkeeping ----------------
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string msg);
        total++;
        bad++;
        $display("FAIL %s", msg);
    endtask

    function automatic beat_t pack4(input logic [15:0] a, input logic [15:0] b,
                                    input logic [15:0] c, input logic [15:0] d);
        return {d, c, b, a};
    endfunction

    // Reference activation: a lane survives when its signed value is above zero.
    function automatic beat_t model_beat(input beat_t x, input logic byp);
        beat_t r;
        int    v;
        r = x;
        if (!byp) begin
            for (int i = 0; i < LANES; i++) begin
                v = int'($signed(x[i*W +: W]));
                if (v <= 0) r[i*W +: W] = '0;
            end
        end
        return r;
    endfunction

    // ---------------- scoreboard / reference model ----------------
    logic [DW:0] exp_q[$];       // {last, data}
    beat_t       got_q[$];
    int          acc_cyc_q[$];
    int          done_cyc_q[$];
    int          start_cyc_q[$];
    int          acc_total = 0;

    int    m_idx = 0;
    logic  m_idle = 1'b1;
    logic  m_run = 1'b0;
    logic  m_ov = 1'b0;
    logic  m_apr = 1'b0;
    logic  m_done = 1'b0;
    logic  m_byp = 1'b0;
    logic  hold_prev = 1'b0;
    beat_t data_prev = '0;
    logic  last_prev = 1'b0;

    always @(negedge ap_clk) begin
        logic        acc;
        logic        cons;
        logic        nxt_done;
        logic [DW:0] e;
        if (!ap_rst_n) begin
            m_idle = 1'b1; m_run = 1'b0; m_ov = 1'b0; m_apr = 1'b0;
            m_done = 1'b0; m_idx = 0; hold_prev = 1'b0;
            exp_q.delete();
        end else begin
            chk("ap_idle", DW'(ap_idle), DW'(m_idle));
            chk("in_ready", DW'(bus.in_ready), DW'(m_run && (!m_ov || bus.out_ready)));
            chk("out_valid", DW'(bus.out_valid), DW'(m_ov));
            chk("ap_ready", DW'(ap_ready), DW'(m_apr));
            chk("ap_done", DW'(ap_done), DW'(m_done));
            if (hold_prev) begin
                chk("hold_data", bus.out_data, data_prev);
                chk("hold_last", DW'(bus.out_last), DW'(last_prev));
            end
            acc  = bus.in_valid && bus.in_ready;
            cons = bus.out_valid && bus.out_ready;
            nxt_done = 1'b0;
            if (cons) begin
                got_q.push_back(bus.out_data);
                if (exp_q.size() == 0) begin
                    fail_now($sformatf("extra_beat: got %h expected no beat", bus.out_data));
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", bus.out_data, e[DW-1:0]);
                    chk("out_last", DW'(bus.out_last), DW'(e[DW]));
                    nxt_done = e[DW];
                end
            end
            m_apr = acc && (m_idx == NB - 1);
            if (acc) begin
                exp_q.push_back({(m_idx == NB - 1), model_beat(bus.in_data, m_byp)});
                m_idx++;
                if (m_idx == NB) m_run = 1'b0;
                acc_cyc_q.push_back(cyc);
                acc_total++;
            end
            m_ov = acc || (m_ov && !bus.out_ready);
            hold_prev = bus.out_valid && !bus.out_ready;
            data_prev = bus.out_data;
            last_prev = bus.out_last;
            if (m_done) begin
                m_idle = 1'b1;
                done_cyc_q.push_back(cyc);
            end else if (m_idle && ap_start) begin
                m_idle = 1'b0;
                m_run  = 1'b1;
                m_idx  = 0;
                m_byp  = cfg_bypass;
                start_cyc_q.push_back(cyc);
            end
            m_done = nxt_done;
        end
    end

    // ---------------- driver tasks ----------------
    beat_t vec[NB];
    beat_t va[NB];
    beat_t ra[NB];
    beat_t vb[NB];
    beat_t rb[NB];

    task automatic clear_logs();
        got_q.delete();
        acc_cyc_q.delete();
        done_cyc_q.delete();
        start_cyc_q.delete();
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge ap_clk);
            n++;
        end while (!ap_done && n < 100);
        if (!ap_done) fail_now("done_timeout: ap_done never pulsed");
        @(posedge ap_clk);
        #1;
    endtask

    // One vector: optional output stall after a beat, optional cfg_bypass
    // toggle after a beat, optional early return after a beat (no drain).
    task automatic send_vector(input logic byp, input int stall_beat, input int stall_len,
                               input int toggle_beat, input int stop_after);
        int n;
        @(posedge ap_clk); #1;
        ap_start = 1'b1;
        cfg_bypass = byp;
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        for (int b = 0; b < NB; b++) begin
            bus.in_valid = 1'b1;
            bus.in_data = vec[b];
            n = 0;
            do begin
                @(negedge ap_clk);
                n++;
            end while (!bus.in_ready && n < 100);
            if (!bus.in_ready) begin
                fail_now($sformatf("accept_timeout: beat %0d not accepted", b));
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge ap_clk); #1;
            bus.in_valid = 1'b0;
            if (b == toggle_beat) cfg_bypass = ~cfg_bypass;
            if (b == stop_after) return;
            if (b == stall_beat) begin
                if (b + 1 < NB) begin
                    bus.in_valid = 1'b1;
                    bus.in_data = vec[b + 1];
                end
                bus.out_ready = 1'b0;
                repeat (stall_len) @(posedge ap_clk);
                #1;
                bus.out_ready = 1'b1;
            end
        end
        wait_done();
    endtask

    task automatic check_got(input string tag, input int base, input beat_t e[NB]);
        for (int i = 0; i < NB; i++) begin
            if (base + i < got_q.size()) begin
                chk($sformatf("%s_beat%0d", tag, i), got_q[base + i], e[i]);
            end else begin
                fail_now($sformatf("%s_beat%0d: got no beat expected %h", tag, i, e[i]));
            end
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int a0;
        int dn;
        int n;
        int feed;
        beat_t tbl[2*NB];

        va[0] = pack4(16'h0100, 16'hFF00, 16'h0000, 16'h7FFF);
        va[1] = pack4(16'h8000, 16'h0001, 16'hFFFF, 16'h4000);
        va[2] = pack4(16'h1234, 16'h8001, 16'h0FFF, 16'hC000);
        va[3] = pack4(16'hFFFE, 16'h7FFE, 16'h0002, 16'h8000);
        ra[0] = pack4(16'h0100, 16'h0000, 16'h0000, 16'h7FFF);
        ra[1] = pack4(16'h0000, 16'h0001, 16'h0000, 16'h4000);
        ra[2] = pack4(16'h1234, 16'h0000, 16'h0FFF, 16'h0000);
        ra[3] = pack4(16'h0000, 16'h7FFE, 16'h0002, 16'h0000);
        vb[0] = pack4(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        vb[1] = pack4(16'h8000, 16'h0001, 16'hFFFF, 16'h4000);
        vb[2] = pack4(16'h7FFF, 16'h8000, 16'h0100, 16'hFF00);
        vb[3] = pack4(16'h0000, 16'hFFFF, 16'h0010, 16'h8010);
        rb[0] = pack4(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        rb[1] = pack4(16'h0000, 16'h0001, 16'h0000, 16'h4000);
        rb[2] = pack4(16'h7FFF, 16'h0000, 16'h0100, 16'h0000);
        rb[3] = pack4(16'h0000, 16'h0000, 16'h0010, 16'h0000);

        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b1;

        // Reset state.
        ap_rst_n = 1'b0;
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        chk("rst_idle", DW'(ap_idle), DW'(1));
        chk("rst_out_valid", DW'(bus.out_valid), DW'(0));
        chk("rst_out_data", bus.out_data, '0);
        chk("rst_out_last", DW'(bus.out_last), DW'(0));
        chk("rst_done", DW'(ap_done), DW'(0));
        chk("rst_ready", DW'(ap_ready), DW'(0));
        chk("rst_in_ready", DW'(bus.in_ready), DW'(0));
        chk("rst_state", DW'(dbg_state), DW'(S_IDLE));
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;

        // Basic run, full throughput.
        clear_logs();
        vec = va;
        send_vector(1'b0, -1, 0, -1, -1);
        check_got("basic", 0, ra);
        if (acc_cyc_q.size() == NB) chk("basic_span", DW'(acc_cyc_q[NB-1] - acc_cyc_q[0]), DW'(NB - 1));
        else fail_now($sformatf("basic_accepts: got %0d expected %0d", acc_cyc_q.size(), NB));
        if (done_cyc_q.size() == 1 && start_cyc_q.size() == 1)
            chk("basic_run_len", DW'(done_cyc_q[0] - start_cyc_q[0]), DW'(NB + 2));
        else fail_now("basic_run_len: start/done not observed once each");
        chk("basic_idle_after", DW'(ap_idle), DW'(1));

        // Backpressure: 5-cycle stall after beat 1.
        clear_logs();
        vec = vb;
        send_vector(1'b0, 1, 5, -1, -1);
        check_got("stall", 0, rb);
        chk("stall_count", DW'(got_q.size()), DW'(NB));
        if (acc_cyc_q.size() == NB) chk("stall_gap", DW'(acc_cyc_q[2] - acc_cyc_q[1]), DW'(6));
        else fail_now($sformatf("stall_accepts: got %0d expected %0d", acc_cyc_q.size(), NB));

        // Bypass latched at start, toggled after beat 1.
        clear_logs();
        vec = va;
        send_vector(1'b1, -1, 0, 1, -1);
        check_got("bypass", 0, va);
        cfg_bypass = 1'b0;

        // Asynchronous reset after beat 2, then a fresh vector.
        clear_logs();
        vec = vb;
        send_vector(1'b0, -1, 0, -1, 2);
        #1;
        ap_rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", DW'(bus.out_valid), DW'(0));
        chk("mid_rst_done", DW'(ap_done), DW'(0));
        chk("mid_rst_ready", DW'(ap_ready), DW'(0));
        chk("mid_rst_idle", DW'(ap_idle), DW'(1));
        chk("mid_rst_state", DW'(dbg_state), DW'(S_IDLE));
        repeat (2) @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        clear_logs();
        vec = va;
        send_vector(1'b0, -1, 0, -1, -1);
        check_got("after_rst", 0, ra);

        // ap_start and in_valid held high: two back-to-back runs.
        clear_logs();
        for (int i = 0; i < NB; i++) begin
            tbl[i] = va[i];
            tbl[NB + i] = vb[i];
        end
        a0 = acc_total;
        @(posedge ap_clk); #1;
        feed = 0;
        ap_start = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = tbl[0];
        dn = 0;
        n = 0;
        while (dn < 2 && n < 200) begin
            @(negedge ap_clk);
            n++;
            if (ap_done) begin
                dn++;
            end else if (bus.in_ready) begin
                @(posedge ap_clk); #1;
                feed++;
                bus.in_data = tbl[feed % (2*NB)];
            end
        end
        if (dn < 2) fail_now($sformatf("held_timeout: got %0d done pulses expected 2", dn));
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge ap_clk);
        @(negedge ap_clk);
        chk("held_accepts", DW'(acc_total - a0), DW'(2*NB));
        chk("held_idle_end", DW'(ap_idle), DW'(1));
        check_got("held_run0", 0, ra);
        check_got("held_run1", NB, rb);
        if (done_cyc_q.size() >= 1 && acc_cyc_q.size() > NB)
            chk("held_restart_gap", DW'(acc_cyc_q[NB] - done_cyc_q[0]), DW'(2));
        else fail_now("held_restart_gap: second run not observed");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
